// File: rtl/text_pkg.sv
// Shared types and character codes for the keyboard text-line path.
package text_pkg;

    localparam int TEXT_CHAR_W = 16;

    typedef logic [TEXT_CHAR_W-1:0] char_t;

    localparam char_t CHAR_SPACE = 16'd0;
    localparam char_t CHAR_A     = 16'd1;
    localparam char_t CHAR_Z     = 16'd26;
    localparam char_t CHAR_BKSP  = 16'd27;
    localparam char_t CHAR_ENTER = 16'd28;

    typedef enum logic {
        EDIT   = 1'b0,
        COMMIT = 1'b1
    } line_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchroniser for a slow level strobe plus a registered
// single-cycle pulse on each rising edge of the synchronised level.
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic strobe_in,
    output logic event_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] primed_q;
    logic [SYNC_STAGES-1:0] primed_d;
    logic                   event_q;
    logic                   event_d;

    // primed_q marks stages that hold a real post-reset sample, so a strobe
    // already high at reset release is seen as a level, never as an edge.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], strobe_in};
        primed_d = {primed_q[SYNC_STAGES-2:0], 1'b1};
        event_d  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1]
                   & primed_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q   <= '0;
            primed_q <= '0;
            event_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            primed_q <= primed_d;
            event_q  <= event_d;
        end
    end

    assign event_out = event_q;

endmodule

// File: rtl/text_line_buffer.sv
// Editable line of keyboard characters, committed downstream on enter
// through a valid/ready handshake, with a 1-cycle-latency read port.
module text_line_buffer #(
    parameter int MAX_CHARS   = 32,
    parameter int CHAR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         key_pressed_in,
    input  logic                         enter_pressed_in,
    input  logic                         bksp_pressed_in,
    input  logic [CHAR_W-1:0]            character_in,
    input  logic [$clog2(MAX_CHARS)-1:0] rd_addr_in,
    output logic [CHAR_W-1:0]            rd_char_out,
    output logic [$clog2(MAX_CHARS):0]   length_out,
    output logic                         line_valid_out,
    input  logic                         line_ready_in,
    output logic                         overflow_out
);

    import text_pkg::*;

    localparam int ADDR_W = $clog2(MAX_CHARS);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHARS);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic key_ev;
    logic enter_ev;
    logic bksp_ev;

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .strobe_in (key_pressed_in),
        .event_out (key_ev)
    );

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .strobe_in (enter_pressed_in),
        .event_out (enter_ev)
    );

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bksp_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .strobe_in (bksp_pressed_in),
        .event_out (bksp_ev)
    );

    logic [CHAR_W-1:0] mem [MAX_CHARS];
    logic [CHAR_W-1:0] char_hold_q;

    line_state_t       state_q,    state_d;
    logic [LEN_W-1:0]  length_q,   length_d;
    logic              valid_q,    valid_d;
    logic              overflow_q, overflow_d;
    logic [CHAR_W-1:0] rd_char_q,  rd_char_d;
    logic              wr_en;

    // Handshake: line_valid_out rises the cycle after an enter event and stays
    // high, with length_out frozen, until a cycle where line_ready_in is also
    // high; ready alone has no effect.
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;
        wr_en      = 1'b0;
        rd_char_d  = ({1'b0, rd_addr_in} < length_q) ? mem[rd_addr_in]
                                                      : CHAR_W'(CHAR_SPACE);
        case (state_q)
            EDIT: begin
                if (enter_ev) begin
                    state_d = COMMIT;
                    valid_d = 1'b1;
                end else if (bksp_ev) begin
                    if (length_q != '0) length_d = length_q - LEN_ONE;
                end else if (key_ev) begin
                    if (length_q != LEN_MAX) begin
                        wr_en    = 1'b1;
                        length_d = length_q + LEN_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (valid_q && line_ready_in) begin
                    state_d  = EDIT;
                    valid_d  = 1'b0;
                    length_d = '0;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= EDIT;
            length_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rd_char_q  <= '0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            rd_char_q  <= rd_char_d;
        end
    end

    // character_in is quasi-static, so a plain register suffices as holding stage.
    always_ff @(posedge clk_in) begin
        char_hold_q <= character_in;
        if (wr_en) mem[length_q[ADDR_W-1:0]] <= char_hold_q;
    end

    assign rd_char_out    = rd_char_q;
    assign length_out     = length_q;
    assign line_valid_out = valid_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_text_line_buffer.sv
// Bench for text_line_buffer: strobe presses against a small line model,
// with expected lengths and read data queued and popped at the DUT output.
module tb_text_line_buffer;

  import text_pkg::*;

  localparam int MAX = 32;
  localparam int CW  = 16;
  localparam int SS  = 2;
  localparam int AW  = 5;
  localparam int LW  = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          key;
  logic          enter;
  logic          bksp;
  logic [CW-1:0] chr;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_char;
  logic [LW-1:0] length;
  logic          valid;
  logic          ready;
  logic          ovf;

  always #5 clk = ~clk;

  text_line_buffer #(.MAX_CHARS(MAX), .CHAR_W(CW), .SYNC_STAGES(SS)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .key_pressed_in   (key),
    .enter_pressed_in (enter),
    .bksp_pressed_in  (bksp),
    .character_in     (chr),
    .rd_addr_in       (rd_addr),
    .rd_char_out      (rd_char),
    .length_out       (length),
    .line_valid_out   (valid),
    .line_ready_in    (ready),
    .overflow_out     (ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] len_q[$];
  logic [31:0] rd_q[$];
  int          model_len = 0;
  bit          model_commit = 1'b0;
  logic [CW-1:0] model_mem [MAX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Raise one strobe (key, bksp or enter by code) for hold cycles; the event
  // lands on the (SS+1)th rising edge after the strobe rises.
  task automatic press(input logic [CW-1:0] code, input int hold);
    bit is_enter = (code == CHAR_ENTER);
    bit is_bksp  = (code == CHAR_BKSP);
    int prev_len = model_len;
    bit exp_ovf  = 1'b0;
    if (!model_commit) begin
      if (is_enter) model_commit = 1'b1;
      else if (is_bksp) begin
        if (model_len > 0) model_len--;
      end else if (model_len < MAX) begin
        model_mem[model_len] = code;
        model_len++;
      end else exp_ovf = 1'b1;
    end
    len_q.push_back(model_len);
    if (is_enter) enter = 1'b1;
    else if (is_bksp) bksp = 1'b1;
    else begin
      key = 1'b1;
      chr = code;
    end
    tick();
    tick();
    check("len_early", length, prev_len);
    check("ovf_early", ovf, 0);
    tick();
    check("len", length, len_q.pop_front());
    check("ovf", ovf, exp_ovf);
    check("valid", valid, model_commit);
    if (model_commit && ready) begin
      model_commit = 1'b0;
      model_len    = 0;
    end
    tick();
    check("ovf_clr", ovf, 0);
    check("valid_next", valid, model_commit);
    check("len_next", length, model_len);
    repeat (hold - 4) tick();
    key   = 1'b0;
    enter = 1'b0;
    bksp  = 1'b0;
    repeat (6) tick();
  endtask

  task automatic rd_check(input int addr);
    logic [31:0] exp;
    exp = (addr < model_len) ? 32'(model_mem[addr]) : 32'd0;
    rd_q.push_back(exp);
    rd_addr = addr[AW-1:0];
    tick();
    check("rd", rd_char, rd_q.pop_front());
  endtask

  task automatic flush();
    ready = 1'b1;
    press(CHAR_ENTER, 10);
    check("flush_valid", valid, 0);
    check("flush_len", length, 0);
    ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    key     = 1'b0;
    enter   = 1'b0;
    bksp    = 1'b0;
    chr     = '0;
    rd_addr = '0;
    ready   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_len", length, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd", rd_char, 0);
    repeat (4) tick();

    // 1: 'h','i'
    press(16'd8, 50);
    press(16'd9, 50);
    rd_check(0);
    rd_check(1);
    rd_check(2);
    flush();

    // 2: three chars, four backspaces, then code 5
    for (int i = 0; i < 3; i++) press(16'($urandom_range(1, 26)), 10);
    for (int i = 0; i < 4; i++) press(CHAR_BKSP, 10);
    check("bksp_floor", length, 0);
    press(16'd5, 10);
    rd_check(0);
    check("t2_len", length, 1);
    flush();

    // 3: fill to MAX, then one more key overflows
    for (int i = 0; i < MAX; i++) press(16'($urandom_range(1, 26)), 10);
    check("full_len", length, MAX);
    press(16'd7, 10);
    rd_check(MAX - 1);
    rd_check(0);
    flush();

    // 4: commit held off by ready, extra events ignored
    press(16'd2, 10);
    press(16'd3, 10);
    press(CHAR_ENTER, 20);
    press(16'd4, 20);
    press(CHAR_BKSP, 20);
    check("hold_valid", valid, 1);
    check("hold_len", length, 2);
    rd_check(1);
    ready = 1'b1;
    tick();
    model_commit = 1'b0;
    model_len    = 0;
    check("hs_valid", valid, 0);
    check("hs_len", length, 0);
    ready = 1'b0;
    rd_check(0);

    // 5: empty-line commit with ready tied high, then next key to mem[0]
    flush();
    press(16'd12, 10);
    rd_check(0);
    flush();

    // 6: reset during COMMIT with key strobe held high
    press(16'd6, 10);
    press(CHAR_ENTER, 10);
    key = 1'b1;
    chr = 16'd4;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_len    = 0;
    model_commit = 1'b0;
    check("rst2_len", length, 0);
    check("rst2_valid", valid, 0);
    check("rst2_ovf", ovf, 0);
    check("rst2_rd", rd_char, 0);
    repeat (20) tick();
    check("stuck_key_len", length, 0);
    key = 1'b0;
    repeat (6) tick();
    press(16'd3, 10);
    rd_check(0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
